// File: rtl/multi_mode_counter.sv
// multi_mode_counter: parametrised timer/event counter with runtime threshold,
// up/down direction, wrap or one-shot mode, prescaler, enable, synchronous
// load/abort, a registered terminal-count pulse and busy/done status flags.
module multi_mode_counter #(
    parameter int WIDTH    = 32,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             start,
    input  logic             abort,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] thresh,
    input  logic             dir,
    input  logic             oneshot,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             busy,
    output logic             done
);

    // Prescaler needs at least one bit even when PRESCALE == 1.
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [PW-1:0]    presc;
    logic [WIDTH-1:0] thresh_q;
    logic             dir_q;
    logic             oneshot_q;

    logic [WIDTH-1:0] start_val;
    logic [WIDTH-1:0] target;
    logic             tick;
    logic             terminal;

    // Counting runs from start_val toward target in the captured direction.
    assign start_val = dir_q ? thresh_q : '0;
    assign target    = dir_q ? '0 : thresh_q;
    assign tick      = (state == RUN) && en && (presc == PRE_LAST);
    assign terminal  = (count == target);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; abort > load > start > tick.
    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = IDLE;
        end else if (load) begin
            state_nxt = state;
        end else if (start) begin
            state_nxt = RUN;
        end else if (tick && terminal && oneshot_q) begin
            state_nxt = DONE;
        end
    end

    // Status flags decoded straight from the state.
    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

    // Count, prescaler, captured configuration and terminal-count pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count     <= '0;
            presc     <= '0;
            tc        <= 1'b0;
            thresh_q  <= '0;
            dir_q     <= 1'b0;
            oneshot_q <= 1'b0;
        end else begin
            tc <= 1'b0;
            if (abort) begin
                count <= '0;
                presc <= '0;
            end else if (load) begin
                count <= load_val;
                presc <= '0;
            end else if (start) begin
                // Start value uses the live inputs since they are captured now.
                thresh_q  <= thresh;
                dir_q     <= dir;
                oneshot_q <= oneshot;
                count     <= dir ? thresh : '0;
                presc     <= '0;
            end else if ((state == RUN) && en) begin
                if (presc == PRE_LAST) begin
                    presc <= '0;
                    if (terminal) begin
                        tc <= 1'b1;
                        if (!oneshot_q) begin
                            count <= start_val;
                        end
                    end else if (dir_q) begin
                        count <= count - WIDTH'(1);
                    end else begin
                        count <= count + WIDTH'(1);
                    end
                end else begin
                    presc <= presc + PW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_multi_mode_counter.sv
// Directed testbench for multi_mode_counter: two WIDTH=8 instances
// (PRESCALE=1 and PRESCALE=4) driven from shared stimulus.
module tb_multi_mode_counter;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic       start;
    logic       abort;
    logic       load;
    logic [7:0] load_val;
    logic [7:0] thresh;
    logic       dir;
    logic       oneshot;

    logic [7:0] count;
    logic       tc, busy, done;
    logic [7:0] count4;
    logic       tc4, busy4, done4;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    multi_mode_counter #(.WIDTH(8), .PRESCALE(1)) dut (
        .clk(clk), .reset(reset), .en(en), .start(start), .abort(abort),
        .load(load), .load_val(load_val), .thresh(thresh), .dir(dir),
        .oneshot(oneshot), .count(count), .tc(tc), .busy(busy), .done(done)
    );

    multi_mode_counter #(.WIDTH(8), .PRESCALE(4)) dut4 (
        .clk(clk), .reset(reset), .en(en), .start(start), .abort(abort),
        .load(load), .load_val(load_val), .thresh(thresh), .dir(dir),
        .oneshot(oneshot), .count(count4), .tc(tc4), .busy(busy4), .done(done4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [7:0] th, input logic d, input logic os);
        thresh = th; dir = d; oneshot = os; start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic do_abort();
        abort = 1'b1;
        step();
        abort = 1'b0;
    endtask

    initial begin
        reset = 1'b1; en = 1'b1; start = 1'b0; abort = 1'b0; load = 1'b0;
        load_val = '0; thresh = '0; dir = 1'b0; oneshot = 1'b0;
        step(); step();
        reset = 1'b0;
        step();

        // Reset state
        check("rst_count", count, 0);
        check("rst_tc",    tc,    0);
        check("rst_busy",  busy,  0);
        check("rst_done",  done,  0);
        check("rst_count4", count4, 0);

        // Up, wrap, thresh=5, PRESCALE=1: 0,1,2,3,4,5,0,1
        do_start(8'd5, 1'b0, 1'b0);
        check("t1_count0", count, 0);
        check("t1_busy0",  busy,  1);
        check("t1_tc0",    tc,    0);
        for (int i = 1; i <= 7; i++) begin
            step();
            check($sformatf("t1_count%0d", i), count, i % 6);
            check($sformatf("t1_tc%0d", i),    tc,    (i == 6) ? 1 : 0);
            check($sformatf("t1_busy%0d", i),  busy,  1);
        end

        // PRESCALE=4, thresh=2, up, wrap: one step every 4 cycles, tc per 12
        do_abort();
        do_start(8'd2, 1'b0, 1'b0);
        check("t2_count0", count4, 0);
        for (int i = 1; i <= 12; i++) begin
            step();
            check($sformatf("t2_count%0d", i), count4, (i / 4) % 3);
            check($sformatf("t2_tc%0d", i),    tc4,    (i == 12) ? 1 : 0);
        end
        // en low for 3 cycles delays the next tick by exactly 3 cycles
        en = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            step();
            check($sformatf("t2_frz_count%0d", i), count4, 0);
            check($sformatf("t2_frz_tc%0d", i),    tc4,    0);
        end
        en = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            step();
            check($sformatf("t2_dly_count%0d", i), count4, 0);
        end
        step();
        check("t2_dly_count4", count4, 1);

        // Down, one-shot, thresh=3: 3,2,1,0 then tc + DONE, count holds 0
        do_abort();
        do_start(8'd3, 1'b1, 1'b1);
        thresh = 8'd9; dir = 1'b0; oneshot = 1'b0;   // ignored until next start
        check("t3_count0", count, 3);
        for (int i = 1; i <= 3; i++) begin
            step();
            check($sformatf("t3_count%0d", i), count, 3 - i);
            check($sformatf("t3_tc%0d", i),    tc,    0);
        end
        step();
        check("t3_term_count", count, 0);
        check("t3_term_tc",    tc,    1);
        check("t3_term_done",  done,  1);
        check("t3_term_busy",  busy,  0);
        step();
        check("t3_hold_count", count, 0);
        check("t3_hold_tc",    tc,    0);
        check("t3_hold_done",  done,  1);
        do_start(8'd3, 1'b1, 1'b1);
        check("t3_restart_count", count, 3);
        check("t3_restart_busy",  busy,  1);
        check("t3_restart_done",  done,  0);

        // Up, wrap, thresh=10, load 200 mid-run: 200..255,0..10 then tc
        do_abort();
        do_start(8'd10, 1'b0, 1'b0);
        step(); step();
        check("t4_count_pre", count, 2);
        load = 1'b1; load_val = 8'd200;
        step();
        load = 1'b0;
        check("t4_load_count", count, 200);
        check("t4_load_busy",  busy,  1);
        for (int i = 1; i <= 66; i++) begin
            logic [7:0] e;
            e = 8'(200 + i);
            step();
            check($sformatf("t4_count%0d", i), count, e);
            check($sformatf("t4_tc%0d", i),    tc,    0);
        end
        step();
        check("t4_term_count", count, 0);
        check("t4_term_tc",    tc,    1);
        step();
        check("t4_after_count", count, 1);
        // start+load same cycle: load wins
        start = 1'b1; load = 1'b1; load_val = 8'd50;
        step();
        start = 1'b0; load = 1'b0;
        check("t4_sl_count", count, 50);
        check("t4_sl_busy",  busy,  1);
        step();
        check("t4_sl_next", count, 51);
        // abort+load same cycle: abort wins
        abort = 1'b1; load = 1'b1; load_val = 8'd77;
        step();
        abort = 1'b0; load = 1'b0;
        check("t4_al_count", count, 0);
        check("t4_al_busy",  busy,  0);
        check("t4_al_done",  done,  0);
        step();
        check("t4_idle_count", count, 0);

        // Asynchronous reset mid-run at count=7
        do_start(8'd20, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) step();
        check("t5_count_pre", count, 7);
        check("t5_busy_pre",  busy,  1);
        #1 reset = 1'b1;
        #1;
        check("t5_async_count", count, 0);
        check("t5_async_tc",    tc,    0);
        check("t5_async_busy",  busy,  0);
        check("t5_async_done",  done,  0);
        step();
        reset = 1'b0;
        step(); step();
        check("t5_post_count", count, 0);
        check("t5_post_busy",  busy,  0);
        do_start(8'd20, 1'b0, 1'b0);
        check("t5_restart_busy", busy, 1);
        step();
        check("t5_restart_count", count, 1);

        // thresh=0, up, wrap: count stays 0, tc every tick
        do_start(8'd0, 1'b0, 1'b0);
        check("t6_count0", count, 0);
        check("t6_tc0",    tc,    0);
        for (int i = 1; i <= 3; i++) begin
            step();
            check($sformatf("t6_count%0d", i), count, 0);
            check($sformatf("t6_tc%0d", i),    tc,    1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/multi_mode_counter.md
Name: multi_mode_counter

Overview:
- Parametrised successor to the fixed-threshold free-running counter.
- Adds: configurable width; runtime threshold; up/down direction; wrap or one-shot mode; prescaler; enable; synchronous load/abort; terminal-count pulse; status flags.
- Used as a general timer/event counter in datapath and test infrastructure.
- One instance per channel; no shared state.

Parameters:
- WIDTH, 32, counter and threshold width in bits (>=2).
- PRESCALE, 1, enabled clk cycles per count tick (>=1). PRESCALE=1 gives one tick every enabled cycle.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- en  in  1  count enable; low freezes count and prescaler (state unchanged).
- start  in  1  single-cycle pulse: capture thresh/dir/oneshot, reload start value, enter RUN.
- abort  in  1  synchronous: go to IDLE, count<=0.
- load  in  1  synchronous: count<=load_val, prescaler cleared, state unchanged.
- load_val  in  WIDTH  value for load.
- thresh  in  WIDTH  target magnitude, sampled on start.
- dir  in  1  0=up, 1=down, sampled on start.
- oneshot  in  1  0=wrap, 1=one-shot, sampled on start.
- count  out  WIDTH  current count (registered).
- tc  out  1  one-cycle terminal-count pulse (registered).
- busy  out  1  state==RUN.
- done  out  1  state==DONE.

Behaviour:
- Reset (async assert, deassert synchronous to clk by system):
  - state=IDLE; count=0; tc=0; busy=0; done=0; prescaler=0; captured regs=0.
- States: IDLE, RUN, DONE.
  - IDLE -start-> RUN.
  - RUN -terminal tick with oneshot_q=1-> DONE.
  - DONE -start-> RUN.
  - Any state -abort-> IDLE.
- Start value and target:
  - Up: start value 0, target thresh_q.
  - Down: start value thresh_q, target 0.
- On start:
  - Capture thresh_q/dir_q/oneshot_q.
  - count<=start value; prescaler<=0; tc<=0.
  - Start while RUN restarts.
- Tick generation:
  - In RUN with en=1, prescaler increments each cycle.
  - A tick occurs on the cycle prescaler==PRESCALE-1; prescaler then returns to 0.
  - For PRESCALE=1, a tick occurs every enabled RUN cycle.
- Tick when count!=target: count<=count+1 (up) or count-1 (down), modulo 2^WIDTH.
- Tick when count==target (terminal tick):
  - tc<=1 for exactly that cycle.
  - Wrap mode: count<=start value; stay RUN.
  - One-shot mode: count holds target; state<=DONE.
- Wrap period is therefore (thresh_q+1) ticks.
- thresh=0: count stays 0 and every tick is terminal.
- tc is 0 on every cycle that is not a terminal tick.
- Priority in one cycle: abort > load > start > tick.
  - Lower-priority actions are suppressed that cycle.
  - start+load same cycle: load wins, no state change.
- Load behaviour:
  - Allowed in any state.
  - In IDLE/DONE: only count changes.
  - In RUN: counting continues from load_val.
  - A load_val past target (e.g. > thresh_q when counting up) counts modularly through wrap-around until it reaches target. No early termination.
- en=0:
  - Count and prescaler frozen; no tc.
  - start/load/abort still act.
- thresh/dir/oneshot changes after start are ignored until the next start.
- count is unchanged in IDLE/DONE except by load, abort or reset.

Test Plan:
- WIDTH=8, PRESCALE=1, thresh=5, dir=0, oneshot=0, en=1; pulse start -> count 0,1,2,3,4,5,0,1 on successive cycles; tc high only on the cycle count goes 5->0 (6th tick); busy=1 throughout.
- PRESCALE=4, thresh=2, up, wrap -> count steps every 4 cycles: 0,1,2,0; tc once per 12 cycles; with en low for 3 cycles mid-run, the sequence is delayed by exactly 3 cycles.
- thresh=3, dir=1, oneshot=1, start -> count 3,2,1,0, then next tick tc=1 and done=1/busy=0; count holds 0; a further start returns to RUN with count=3.
- Up, wrap, thresh=10, load_val=200 loaded mid-run (WIDTH=8) -> count 200..255,0..10, then tc; same-cycle start+load -> load wins; abort+load same cycle -> IDLE, count=0.
- Reset edge cases:
  - Assert reset asynchronously mid-RUN (count=7) -> count, tc, busy, done all 0 before the next clk edge.
  - After release, counting requires a new start.
- thresh=0, up, wrap -> count stays 0, tc high every tick.
